// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and a saturating counter of cycles lost to hazards.
module id_ex_stage #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_ID,
  input  logic [31:0]        pc_ID,
  input  logic [31:0]        imm_ID,
  input  logic [3:0]         rs1,
  input  logic [3:0]         rs2,
  input  logic [3:0]         rd_ID,
  input  logic               rs1_used,
  input  logic               rs2_used,
  input  logic               regfile_we_ID,
  input  logic [1:0]         rd_data_sel_ID,
  input  logic [3:0]         alu_op_ID,
  input  logic [31:0]        rs1_data_ID,
  input  logic [31:0]        rs2_data_ID,
  input  logic               rs1_data_forwarded,
  input  logic               rs2_data_forwarded,
  input  logic               regfile_we_EX,
  input  logic               regfile_we_MEMPREP,
  input  logic               regfile_we_MEMEX,
  input  logic               regfile_we_WB,
  input  logic [3:0]         rd_EX,
  input  logic [3:0]         rd_MEMPREP,
  input  logic [3:0]         rd_MEMEX,
  input  logic [3:0]         rd_WB,
  input  logic               stall_EX,
  input  logic               flush,
  output logic               stall_ID,
  output logic               valid_EX,
  output logic               regfile_we_EX_q,
  output logic [31:0]        pc_EX,
  output logic [31:0]        imm_EX_q,
  output logic [31:0]        rs1_data_EX,
  output logic [31:0]        rs2_data_EX,
  output logic [3:0]         rd_EX_q,
  output logic [1:0]         rd_data_sel_EX_q,
  output logic [3:0]         alu_op_EX,
  output logic [COUNT_W-1:0] hazard_stall_count
);

  logic               hazard_rs1, hazard_rs2, hazard;
  logic               rs1_pending, rs2_pending;
  logic               load_payload;
  logic               valid_d, valid_q;
  logic               we_d, we_q;
  logic [31:0]        pc_d, pc_q, imm_d, imm_q, rs1_data_d, rs1_data_q, rs2_data_d, rs2_data_q;
  logic [3:0]         rd_d, rd_q, alu_op_d, alu_op_q;
  logic [1:0]         sel_d, sel_q;
  logic [COUNT_W-1:0] count_d, count_q;

  // A source is pending when any in-flight writer targets it and the
  // forwarding unit could not supply the value.
  always_comb begin
    rs1_pending = (regfile_we_EX      && rd_EX      == rs1) ||
                  (regfile_we_MEMPREP && rd_MEMPREP == rs1) ||
                  (regfile_we_MEMEX   && rd_MEMEX   == rs1) ||
                  (regfile_we_WB      && rd_WB      == rs1);
    rs2_pending = (regfile_we_EX      && rd_EX      == rs2) ||
                  (regfile_we_MEMPREP && rd_MEMPREP == rs2) ||
                  (regfile_we_MEMEX   && rd_MEMEX   == rs2) ||
                  (regfile_we_WB      && rd_WB      == rs2);
    hazard_rs1  = valid_ID && rs1_used && (rs1 != 4'd0) && !rs1_data_forwarded && rs1_pending;
    hazard_rs2  = valid_ID && rs2_used && (rs2 != 4'd0) && !rs2_data_forwarded && rs2_pending;
    hazard      = hazard_rs1 || hazard_rs2;
    stall_ID    = valid_ID && !flush && (hazard || stall_EX);
  end

  always_comb begin
    valid_d      = valid_q;
    we_d         = we_q;
    load_payload = 1'b0;
    count_d      = count_q;
    if (flush || (!stall_EX && hazard)) begin
      valid_d = 1'b0;
      we_d    = 1'b0;
    end else if (!stall_EX) begin
      valid_d      = valid_ID;
      we_d         = regfile_we_ID && valid_ID;
      load_payload = 1'b1;
    end
    if (!flush && !stall_EX && hazard && (count_q != {COUNT_W{1'b1}}))
      count_d = count_q + 1'b1;

    pc_d       = load_payload ? pc_ID          : pc_q;
    imm_d      = load_payload ? imm_ID         : imm_q;
    rs1_data_d = load_payload ? rs1_data_ID    : rs1_data_q;
    rs2_data_d = load_payload ? rs2_data_ID    : rs2_data_q;
    rd_d       = load_payload ? rd_ID          : rd_q;
    sel_d      = load_payload ? rd_data_sel_ID : sel_q;
    alu_op_d   = load_payload ? alu_op_ID      : alu_op_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rd_q       <= '0;
      sel_q      <= '0;
      alu_op_q   <= '0;
      count_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      we_q       <= we_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rd_q       <= rd_d;
      sel_q      <= sel_d;
      alu_op_q   <= alu_op_d;
      count_q    <= count_d;
    end
  end

  assign valid_EX           = valid_q;
  assign regfile_we_EX_q    = we_q;
  assign pc_EX              = pc_q;
  assign imm_EX_q           = imm_q;
  assign rs1_data_EX        = rs1_data_q;
  assign rs2_data_EX        = rs2_data_q;
  assign rd_EX_q            = rd_q;
  assign rd_data_sel_EX_q   = sel_q;
  assign alu_op_EX          = alu_op_q;
  assign hazard_stall_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written corner sequences,
// and randomized traffic against a behavioural model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ID;
  logic [31:0] pc_ID, imm_ID, rs1_data_ID, rs2_data_ID;
  logic [3:0]  rs1, rs2, rd_ID, alu_op_ID;
  logic        rs1_used, rs2_used, regfile_we_ID, rs1_data_forwarded, rs2_data_forwarded;
  logic [1:0]  rd_data_sel_ID;
  logic        regfile_we_EX, regfile_we_MEMPREP, regfile_we_MEMEX, regfile_we_WB;
  logic [3:0]  rd_EX, rd_MEMPREP, rd_MEMEX, rd_WB;
  logic        stall_EX, flush;

  logic        stall_ID, valid_EX, regfile_we_EX_q;
  logic [31:0] pc_EX, imm_EX_q, rs1_data_EX, rs2_data_EX;
  logic [3:0]  rd_EX_q, alu_op_EX;
  logic [1:0]  rd_data_sel_EX_q;
  logic [31:0] hazard_stall_count;

  logic        s_stall_ID, s_valid_EX, s_we_q;
  logic [31:0] s_pc, s_imm, s_rs1d, s_rs2d;
  logic [3:0]  s_rd, s_alu;
  logic [1:0]  s_sel;
  logic [3:0]  s_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID), .pc_ID(pc_ID), .imm_ID(imm_ID),
    .rs1(rs1), .rs2(rs2), .rd_ID(rd_ID), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .regfile_we_ID(regfile_we_ID), .rd_data_sel_ID(rd_data_sel_ID), .alu_op_ID(alu_op_ID),
    .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .rs1_data_forwarded(rs1_data_forwarded), .rs2_data_forwarded(rs2_data_forwarded),
    .regfile_we_EX(regfile_we_EX), .regfile_we_MEMPREP(regfile_we_MEMPREP),
    .regfile_we_MEMEX(regfile_we_MEMEX), .regfile_we_WB(regfile_we_WB),
    .rd_EX(rd_EX), .rd_MEMPREP(rd_MEMPREP), .rd_MEMEX(rd_MEMEX), .rd_WB(rd_WB),
    .stall_EX(stall_EX), .flush(flush), .stall_ID(stall_ID), .valid_EX(valid_EX),
    .regfile_we_EX_q(regfile_we_EX_q), .pc_EX(pc_EX), .imm_EX_q(imm_EX_q),
    .rs1_data_EX(rs1_data_EX), .rs2_data_EX(rs2_data_EX), .rd_EX_q(rd_EX_q),
    .rd_data_sel_EX_q(rd_data_sel_EX_q), .alu_op_EX(alu_op_EX),
    .hazard_stall_count(hazard_stall_count)
  );

  id_ex_stage #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID), .pc_ID(pc_ID), .imm_ID(imm_ID),
    .rs1(rs1), .rs2(rs2), .rd_ID(rd_ID), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .regfile_we_ID(regfile_we_ID), .rd_data_sel_ID(rd_data_sel_ID), .alu_op_ID(alu_op_ID),
    .rs1_data_ID(rs1_data_ID), .rs2_data_ID(rs2_data_ID),
    .rs1_data_forwarded(rs1_data_forwarded), .rs2_data_forwarded(rs2_data_forwarded),
    .regfile_we_EX(regfile_we_EX), .regfile_we_MEMPREP(regfile_we_MEMPREP),
    .regfile_we_MEMEX(regfile_we_MEMEX), .regfile_we_WB(regfile_we_WB),
    .rd_EX(rd_EX), .rd_MEMPREP(rd_MEMPREP), .rd_MEMEX(rd_MEMEX), .rd_WB(rd_WB),
    .stall_EX(stall_EX), .flush(flush), .stall_ID(s_stall_ID), .valid_EX(s_valid_EX),
    .regfile_we_EX_q(s_we_q), .pc_EX(s_pc), .imm_EX_q(s_imm),
    .rs1_data_EX(s_rs1d), .rs2_data_EX(s_rs2d), .rd_EX_q(s_rd),
    .rd_data_sel_EX_q(s_sel), .alu_op_EX(s_alu),
    .hazard_stall_count(s_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    valid_ID = 0; pc_ID = 0; imm_ID = 0; rs1_data_ID = 0; rs2_data_ID = 0;
    rs1 = 0; rs2 = 0; rd_ID = 0; alu_op_ID = 0; rd_data_sel_ID = 0;
    rs1_used = 0; rs2_used = 0; regfile_we_ID = 0;
    rs1_data_forwarded = 0; rs2_data_forwarded = 0;
    regfile_we_EX = 0; regfile_we_MEMPREP = 0; regfile_we_MEMEX = 0; regfile_we_WB = 0;
    rd_EX = 0; rd_MEMPREP = 0; rd_MEMEX = 0; rd_WB = 0;
    stall_EX = 0; flush = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  // One instruction with a hazard on rs1 through the MEMEX writer
  task automatic drive_hazard(input logic [31:0] pc);
    clear_inputs();
    valid_ID = 1; pc_ID = pc; rs1 = 4'd5; rs1_used = 1;
    regfile_we_MEMEX = 1; rd_MEMEX = 4'd5;
  endtask

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  r1;
    logic        u1, f1;
    logic [3:0]  r2;
    logic        u2, f2;
    logic        we_mx;
    logic [3:0]  rd_mx;
    logic        st_ex, fl;
    logic        e_stall, e_valid;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [3:0] r1, logic u1, logic f1,
                              logic [3:0] r2, logic u2, logic f2, logic we, logic [3:0] rdm,
                              logic se, logic fl, logic es, logic ev, logic [31:0] ep, int ec);
    vec_t t;
    t.valid = v; t.pc = pc; t.r1 = r1; t.u1 = u1; t.f1 = f1; t.r2 = r2; t.u2 = u2; t.f2 = f2;
    t.we_mx = we; t.rd_mx = rdm; t.st_ex = se; t.fl = fl;
    t.e_stall = es; t.e_valid = ev; t.e_pc = ep; t.e_cnt = ec;
    return t;
  endfunction

  // Behavioural model: EX contents as a record, writers as arrays
  typedef struct {
    logic        valid, we;
    logic [31:0] pc, imm, d1, d2;
    logic [3:0]  rd, alu;
    logic [1:0]  sel;
  } ex_t;

  ex_t         m_ex;
  longint      m_cnt;

  function automatic logic m_hazard();
    logic       w_we[4];
    logic [3:0] w_rd[4];
    logic [3:0] src[2];
    logic       use_[2], fwd[2];
    logic       h;
    w_we = '{regfile_we_EX, regfile_we_MEMPREP, regfile_we_MEMEX, regfile_we_WB};
    w_rd = '{rd_EX, rd_MEMPREP, rd_MEMEX, rd_WB};
    src  = '{rs1, rs2};
    use_ = '{rs1_used, rs2_used};
    fwd  = '{rs1_data_forwarded, rs2_data_forwarded};
    h = 0;
    if (valid_ID)
      for (int s = 0; s < 2; s++)
        if (use_[s] && src[s] != 0 && !fwd[s])
          for (int k = 0; k < 4; k++)
            if (w_we[k] && w_rd[k] == src[s]) h = 1;
    return h;
  endfunction

  initial begin
    ex_t    nxt;
    logic   h;
    longint n_cnt;

    clear_inputs();
    rst_n = 0;
    #12;
    chk("reset_valid", valid_EX, 0);
    chk("reset_count", hazard_stall_count, 0);
    chk("reset_pc", pc_EX, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    //          v  pc     r1 u f  r2 u f  we rd se fl  stall valid pc     cnt
    vecs.push_back(mk(1, 32'h100, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0));
    vecs.push_back(mk(1, 32'h104, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0, 32'h100, 1));
    vecs.push_back(mk(1, 32'h104, 5, 1, 1, 0, 0, 0, 1, 5, 0, 0, 0, 1, 32'h104, 1));
    vecs.push_back(mk(1, 32'h108, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h108, 1));
    vecs.push_back(mk(1, 32'h10C, 5, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 32'h10C, 1));
    vecs.push_back(mk(1, 32'h110, 0, 0, 0, 5, 1, 0, 1, 5, 0, 0, 1, 0, 32'h10C, 2));
    vecs.push_back(mk(1, 32'h110, 5, 1, 0, 5, 1, 0, 1, 5, 0, 0, 1, 0, 32'h10C, 3));
    vecs.push_back(mk(1, 32'h114, 5, 1, 0, 5, 1, 0, 1, 6, 0, 0, 0, 1, 32'h114, 3));
    vecs.push_back(mk(1, 32'h118, 5, 1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 1, 32'h114, 3));
    vecs.push_back(mk(1, 32'h118, 5, 1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 1, 32'h114, 3));
    vecs.push_back(mk(1, 32'h118, 5, 1, 0, 0, 0, 0, 1, 5, 1, 0, 1, 1, 32'h114, 3));
    vecs.push_back(mk(1, 32'h118, 5, 1, 0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 32'h114, 3));
    vecs.push_back(mk(0, 32'h11C, 5, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 32'h11C, 3));
    vecs.push_back(mk(1, 32'h120, 2, 1, 0, 0, 0, 0, 1, 5, 0, 1, 0, 0, 32'h11C, 3));

    foreach (vecs[i]) begin
      clear_inputs();
      valid_ID = vecs[i].valid; pc_ID = vecs[i].pc; imm_ID = ~vecs[i].pc;
      rs1_data_ID = vecs[i].pc ^ 32'h155; rs2_data_ID = vecs[i].pc + 32'h7;
      rs1 = vecs[i].r1; rs1_used = vecs[i].u1; rs1_data_forwarded = vecs[i].f1;
      rs2 = vecs[i].r2; rs2_used = vecs[i].u2; rs2_data_forwarded = vecs[i].f2;
      regfile_we_MEMEX = vecs[i].we_mx; rd_MEMEX = vecs[i].rd_mx;
      stall_EX = vecs[i].st_ex; flush = vecs[i].fl; regfile_we_ID = 1;
      #1;
      chk($sformatf("vec%0d_stall_ID", i), stall_ID, vecs[i].e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid_EX", i), valid_EX, vecs[i].e_valid);
      chk($sformatf("vec%0d_we_EX_q", i), regfile_we_EX_q, vecs[i].e_valid);
      chk($sformatf("vec%0d_pc_EX", i), pc_EX, vecs[i].e_pc);
      chk($sformatf("vec%0d_rs1_data_EX", i), rs1_data_EX, vecs[i].e_pc ^ 32'h155);
      chk($sformatf("vec%0d_count", i), hazard_stall_count, vecs[i].e_cnt);
    end

    // Saturation of the narrow counter over 20 hazard cycles
    clear_inputs();
    do_reset();
    drive_hazard(32'h200);
    repeat (20) @(posedge clk);
    #1;
    chk("sat_count_w4", s_count, 4'hF);
    chk("sat_count_w32", hazard_stall_count, 20);
    chk("sat_valid", s_valid_EX, 0);

    // Asynchronous reset between edges with valid_EX=1 and count=7
    clear_inputs();
    do_reset();
    drive_hazard(32'h300);
    repeat (7) @(posedge clk);
    #1;
    clear_inputs();
    valid_ID = 1; pc_ID = 32'h304; regfile_we_ID = 1; rd_ID = 4'd9; alu_op_ID = 4'd3;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", valid_EX, 1);
    chk("pre_rst_count", hazard_stall_count, 7);
    drive_hazard(32'h308);
    #1;
    rst_n = 0;
    #1;
    chk("arst_valid", valid_EX, 0);
    chk("arst_we", regfile_we_EX_q, 0);
    chk("arst_pc", pc_EX, 0);
    chk("arst_rd", rd_EX_q, 0);
    chk("arst_alu", alu_op_EX, 0);
    chk("arst_count", hazard_stall_count, 0);
    chk("arst_count_w4", s_count, 0);
    chk("arst_stall_ID_comb", stall_ID, 1);
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    @(posedge clk);
    #1;
    chk("post_rst_count", hazard_stall_count, 0);

    // Randomized traffic against the model
    clear_inputs();
    do_reset();
    m_ex  = '{default: '0};
    m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      valid_ID           = ($urandom_range(0, 99) < 85);
      pc_ID              = $urandom; imm_ID = $urandom;
      rs1_data_ID        = $urandom; rs2_data_ID = $urandom;
      rs1                = 4'($urandom_range(0, 3));
      rs2                = 4'($urandom_range(0, 3));
      rd_ID              = 4'($urandom);
      alu_op_ID          = 4'($urandom);
      rd_data_sel_ID     = 2'($urandom);
      rs1_used           = 1'($urandom); rs2_used = 1'($urandom);
      regfile_we_ID      = 1'($urandom);
      rs1_data_forwarded = ($urandom_range(0, 2) == 0);
      rs2_data_forwarded = ($urandom_range(0, 2) == 0);
      regfile_we_EX      = ($urandom_range(0, 9) < 3);
      regfile_we_MEMPREP = ($urandom_range(0, 9) < 3);
      regfile_we_MEMEX   = ($urandom_range(0, 9) < 3);
      regfile_we_WB      = ($urandom_range(0, 9) < 3);
      rd_EX = 4'($urandom_range(0, 3)); rd_MEMPREP = 4'($urandom_range(0, 3));
      rd_MEMEX = 4'($urandom_range(0, 3)); rd_WB = 4'($urandom_range(0, 3));
      stall_EX           = ($urandom_range(0, 99) < 15);
      flush              = ($urandom_range(0, 99) < 8);
      #1;
      h = m_hazard();
      chk("rnd_stall_ID", stall_ID, valid_ID && !flush && (h || stall_EX));
      nxt   = m_ex;
      n_cnt = m_cnt;
      if (flush) begin
        nxt.valid = 0; nxt.we = 0;
      end else if (stall_EX) begin
        nxt = m_ex;
      end else if (h) begin
        nxt.valid = 0; nxt.we = 0; n_cnt = m_cnt + 1;
      end else begin
        nxt = '{valid: valid_ID, we: regfile_we_ID & valid_ID, pc: pc_ID, imm: imm_ID,
                d1: rs1_data_ID, d2: rs2_data_ID, rd: rd_ID, alu: alu_op_ID,
                sel: rd_data_sel_ID};
      end
      @(posedge clk);
      m_ex  = nxt;
      m_cnt = n_cnt;
      #1;
      chk("rnd_valid", valid_EX, m_ex.valid);
      chk("rnd_we", regfile_we_EX_q, m_ex.we);
      chk("rnd_pc", pc_EX, m_ex.pc);
      chk("rnd_imm", imm_EX_q, m_ex.imm);
      chk("rnd_rs1d", rs1_data_EX, m_ex.d1);
      chk("rnd_rs2d", rs2_data_EX, m_ex.d2);
      chk("rnd_rd", rd_EX_q, m_ex.rd);
      chk("rnd_alu", alu_op_EX, m_ex.alu);
      chk("rnd_sel", rd_data_sel_EX_q, m_ex.sel);
      chk("rnd_count", hazard_stall_count, m_cnt);
      chk("rnd_count_w4", s_count, (m_cnt > 15) ? 15 : m_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
